// File: rtl/opb_register_bank_ppc2simulink.sv
// OPB slave register bank: C_NUM_REGS 32-bit PPC-writable registers feeding
// Simulink user logic, with per-register write strobes, optional self-clearing
// (pulse) registers, byte-enable writes, readback and an error ack for
// in-window indices beyond the implemented register count.
//
// state | meaning
// ------+----------------------------------------------------------------
// IDLE  | waiting for a hit; only accepted once select has been seen low
// ACK   | one-cycle transfer acknowledge (read data / errAck valid here)
// HOLD  | transfer done, waiting for the master to drop OPB_select
module opb_register_bank_ppc2simulink #(
  parameter int                      C_OPB_AWIDTH = 32,
  parameter int                      C_OPB_DWIDTH = 32,
  parameter logic [C_OPB_AWIDTH-1:0] C_BASEADDR   = 32'h0100_0100,
  parameter logic [C_OPB_AWIDTH-1:0] C_HIGHADDR   = 32'h0100_01FF,
  parameter int                      C_NUM_REGS   = 4,
  parameter logic [31:0]             C_INIT_VALUE = 32'h0,
  parameter logic [C_NUM_REGS-1:0]   C_PULSE_MASK = '0
) (
  input  logic                      OPB_Clk,
  input  logic                      OPB_Rst,
  input  logic [0:C_OPB_AWIDTH-1]   OPB_ABus,
  input  logic [0:3]                OPB_BE,
  input  logic [0:C_OPB_DWIDTH-1]   OPB_DBus,
  input  logic                      OPB_RNW,
  input  logic                      OPB_select,
  input  logic                      OPB_seqAddr,
  output logic [0:C_OPB_DWIDTH-1]   Sl_DBus,
  output logic                      Sl_xferAck,
  output logic                      Sl_errAck,
  output logic                      Sl_retry,
  output logic                      Sl_toutSup,
  output logic [32*C_NUM_REGS-1:0]  user_data_out,
  output logic [C_NUM_REGS-1:0]     user_wr_stb
);

  localparam int IDXW = C_OPB_AWIDTH - 2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ACK  = 2'd1,
    ST_HOLD = 2'd2
  } state_t;

  state_t                  state;
  logic                    armed;
  logic [31:0]             regs [C_NUM_REGS];

  logic [C_OPB_AWIDTH-1:0] addr;
  logic [C_OPB_AWIDTH-1:0] offset;
  logic [IDXW-1:0]         idx;
  logic                    hit;
  logic                    idx_valid;
  logic                    accept;
  logic                    wr_accept;
  logic [31:0]             wdata;
  logic [3:0]              be;
  logic [31:0]             be_mask;
  logic [31:0]             rd_data;
  logic                    unused_ok;

  // Big-endian OPB bit numbering maps positionally onto little-endian user
  // bits: OPB_DBus[0] is user bit 31, OPB_BE[0] covers user bits 31:24.
  assign addr      = OPB_ABus;
  assign wdata     = OPB_DBus;
  assign be        = OPB_BE;
  assign be_mask   = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};

  assign offset    = addr - C_BASEADDR;
  assign idx       = offset[C_OPB_AWIDTH-1:2];
  assign hit       = OPB_select && (addr >= C_BASEADDR) && (addr <= C_HIGHADDR);
  assign idx_valid = (idx < IDXW'(C_NUM_REGS));
  assign accept    = (state == ST_IDLE) && armed && hit;
  assign wr_accept = accept && !OPB_RNW && idx_valid;

  assign Sl_retry   = 1'b0;
  assign Sl_toutSup = 1'b0;

  // Sub-word address bits and the burst hint carry no meaning here.
  assign unused_ok = ^{offset[1:0], OPB_seqAddr};

  // Read mux: out-of-range indices fall through to zero.
  always_comb begin
    rd_data = '0;
    for (int i = 0; i < C_NUM_REGS; i++) begin
      if (idx == IDXW'(i)) rd_data = regs[i];
    end
  end

  // Bus handshake FSM with registered slave outputs.
  always_ff @(posedge OPB_Clk or posedge OPB_Rst) begin
    if (OPB_Rst) begin
      state      <= ST_IDLE;
      armed      <= 1'b0;
      Sl_xferAck <= 1'b0;
      Sl_errAck  <= 1'b0;
      Sl_DBus    <= '0;
    end else begin
      // A select still high across reset must be released before a new ack.
      if (!OPB_select) armed <= 1'b1;
      Sl_xferAck <= 1'b0;
      Sl_errAck  <= 1'b0;
      Sl_DBus    <= '0;
      case (state)
        ST_IDLE: begin
          if (accept) begin
            state      <= ST_ACK;
            Sl_xferAck <= 1'b1;
            Sl_errAck  <= !idx_valid;
            if (OPB_RNW) Sl_DBus <= rd_data;
          end
        end
        ST_ACK:  state <= ST_HOLD;
        ST_HOLD: if (!OPB_select) state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Register file and write strobes; writes land on the edge entering ACK.
  always_ff @(posedge OPB_Clk or posedge OPB_Rst) begin
    if (OPB_Rst) begin
      for (int i = 0; i < C_NUM_REGS; i++) begin
        regs[i] <= C_PULSE_MASK[i] ? 32'h0 : C_INIT_VALUE;
      end
      user_wr_stb <= '0;
    end else begin
      for (int i = 0; i < C_NUM_REGS; i++) begin
        if (wr_accept && (idx == IDXW'(i))) begin
          // Pulse registers start from zero so unwritten bytes read back 0.
          if (C_PULSE_MASK[i]) regs[i] <= wdata & be_mask;
          else                 regs[i] <= (regs[i] & ~be_mask) | (wdata & be_mask);
        end else if (C_PULSE_MASK[i]) begin
          regs[i] <= 32'h0;
        end
        user_wr_stb[i] <= wr_accept && (idx == IDXW'(i));
      end
    end
  end

  for (genvar g = 0; g < C_NUM_REGS; g++) begin : g_out
    assign user_data_out[32*g +: 32] = regs[g];
  end

endmodule

// File: tb/tb_opb_register_bank_ppc2simulink.sv
// Self-checking bench for opb_register_bank_ppc2simulink: directed cases
// followed by randomized transfers against an array-based reference model.
module tb_opb_register_bank_ppc2simulink;

  localparam logic [31:0] BASE  = 32'h0100_0100;
  localparam logic [31:0] HIGH  = 32'h0100_01FF;
  localparam int          NREGS = 4;
  localparam logic [31:0] INIT  = 32'hA5A5_0000;
  localparam logic [3:0]  PULSE = 4'b1000;

  logic          clk;
  logic          rst;
  logic [0:31]   opb_abus;
  logic [0:3]    opb_be;
  logic [0:31]   opb_dbus;
  logic          opb_rnw;
  logic          opb_select;
  logic          opb_seqaddr;
  logic [0:31]   sl_dbus;
  logic          sl_xferack;
  logic          sl_errack;
  logic          sl_retry;
  logic          sl_toutsup;
  logic [127:0]  user_data_out;
  logic [3:0]    user_wr_stb;

  int            n_checks = 0;
  int            n_errors = 0;
  logic [31:0]   mdl [NREGS];

  opb_register_bank_ppc2simulink #(
    .C_BASEADDR   (BASE),
    .C_HIGHADDR   (HIGH),
    .C_NUM_REGS   (NREGS),
    .C_INIT_VALUE (INIT),
    .C_PULSE_MASK (PULSE)
  ) dut (
    .OPB_Clk       (clk),
    .OPB_Rst       (rst),
    .OPB_ABus      (opb_abus),
    .OPB_BE        (opb_be),
    .OPB_DBus      (opb_dbus),
    .OPB_RNW       (opb_rnw),
    .OPB_select    (opb_select),
    .OPB_seqAddr   (opb_seqaddr),
    .Sl_DBus       (sl_dbus),
    .Sl_xferAck    (sl_xferack),
    .Sl_errAck     (sl_errack),
    .Sl_retry      (sl_retry),
    .Sl_toutSup    (sl_toutsup),
    .user_data_out (user_data_out),
    .user_wr_stb   (user_wr_stb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [127:0] pack_model();
    logic [127:0] v;
    for (int i = 0; i < NREGS; i++) v[32*i +: 32] = mdl[i];
    return v;
  endfunction

  task automatic reset_model();
    for (int i = 0; i < NREGS; i++) mdl[i] = PULSE[i] ? 32'h0 : INIT;
  endtask

  // One complete transfer, called and returning on a falling edge.
  task automatic do_xfer(input logic [31:0] addr, input bit rnw,
                         input logic [0:3] be, input logic [31:0] data);
    bit           hit, bad;
    int           idx, lat;
    logic [31:0]  exp_rd, nv, rd_ack;
    logic [3:0]   exp_stb, stb_ack;
    logic         err_ack;
    logic [127:0] ud_ack;

    hit     = (addr >= BASE) && (addr <= HIGH);
    idx     = hit ? int'((addr - BASE) / 4) : -1;
    bad     = hit && (idx >= NREGS);
    exp_rd  = 32'h0;
    exp_stb = 4'h0;
    if (hit && !bad) begin
      if (rnw) exp_rd = mdl[idx];
      else begin
        nv = PULSE[idx] ? 32'h0 : mdl[idx];
        for (int k = 0; k < 4; k++)
          if (be[k]) nv[(3-k)*8 +: 8] = data[(3-k)*8 +: 8];
        mdl[idx]     = nv;
        exp_stb[idx] = 1'b1;
      end
    end

    opb_abus   = addr;
    opb_rnw    = rnw;
    opb_be     = be;
    opb_dbus   = data;
    opb_select = 1'b1;
    lat = 0;
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      if (sl_xferack) begin
        lat = c;
        break;
      end
    end
    rd_ack  = sl_dbus;
    err_ack = sl_errack;
    stb_ack = user_wr_stb;
    ud_ack  = user_data_out;
    opb_select = 1'b0;
    opb_abus   = '0;
    opb_dbus   = '0;
    opb_be     = '0;

    chk("ack_latency", lat, hit ? 1 : 0);
    chk("err_ack", err_ack, bad);
    chk("rd_data", rd_ack, exp_rd);
    chk("wr_stb", stb_ack, exp_stb);
    chk("ud_in_ack", ud_ack, pack_model());

    for (int i = 0; i < NREGS; i++) if (PULSE[i]) mdl[i] = 32'h0;
    @(negedge clk);
    chk("post_ack", {sl_xferack, sl_errack}, 2'b00);
    chk("post_dbus", sl_dbus, 32'h0);
    chk("post_stb", user_wr_stb, 4'h0);
    chk("ud_post", user_data_out, pack_model());
    @(negedge clk);
  endtask

  initial begin
    int acks;
    int sel;
    logic [31:0] a;

    rst         = 1'b1;
    opb_abus    = '0;
    opb_be      = '0;
    opb_dbus    = '0;
    opb_rnw     = 1'b0;
    opb_select  = 1'b0;
    opb_seqaddr = 1'b0;
    reset_model();
    repeat (3) @(negedge clk);

    // Reset state
    chk("rst_ud", user_data_out, {32'h0, INIT, INIT, INIT});
    chk("rst_sl", {sl_xferack, sl_errack, sl_retry, sl_toutsup}, 4'b0000);
    chk("rst_dbus", sl_dbus, 32'h0);
    chk("rst_stb", user_wr_stb, 4'h0);
    rst = 1'b0;
    @(negedge clk);
    for (int i = 0; i < NREGS; i++) do_xfer(BASE + 32'(4*i), 1'b1, 4'b1111, 32'h0);

    // Full-word write and readback, including a sub-word address
    do_xfer(BASE + 32'd4, 1'b0, 4'b1111, 32'hDEAD_BEEF);
    do_xfer(BASE + 32'd4, 1'b1, 4'b0000, 32'h0);
    do_xfer(BASE + 32'd6, 1'b1, 4'b0000, 32'h0);

    // Byte-enable write into a cleared register
    do_xfer(BASE, 1'b0, 4'b1111, 32'h0);
    do_xfer(BASE, 1'b0, 4'b0100, 32'h1122_3344);
    chk("byte_write", user_data_out[31:0], 32'h0022_0000);
    do_xfer(BASE, 1'b1, 4'b0000, 32'h0);

    // Pulse register, and a strobe with no byte enables
    do_xfer(BASE + 32'd12, 1'b0, 4'b1111, 32'h0000_0001);
    do_xfer(BASE + 32'd12, 1'b1, 4'b0000, 32'h0);
    do_xfer(BASE + 32'd12, 1'b0, 4'b0001, 32'hFFFF_FF5A);
    do_xfer(BASE + 32'd8, 1'b0, 4'b0000, 32'hFFFF_FFFF);

    // In-window bad index and out-of-window addresses
    do_xfer(BASE + 32'd16, 1'b0, 4'b1111, 32'h5555_AAAA);
    do_xfer(BASE + 32'd16, 1'b1, 4'b0000, 32'h0);
    do_xfer(32'h0100_0200, 1'b1, 4'b0000, 32'h0);
    do_xfer(32'h0100_0200, 1'b0, 4'b1111, 32'h1234_5678);
    do_xfer(BASE - 32'd4, 1'b0, 4'b1111, 32'h1234_5678);

    // Reset during the ACK cycle of a write, select held through reset
    opb_abus   = BASE + 32'd8;
    opb_rnw    = 1'b0;
    opb_be     = 4'b1111;
    opb_dbus   = 32'h1234_5678;
    opb_select = 1'b1;
    @(negedge clk);
    chk("rstack_ack", sl_xferack, 1'b1);
    #1 rst = 1'b1;
    #1;
    reset_model();
    chk("rstack_drop", {sl_xferack, sl_errack}, 2'b00);
    chk("rstack_ud", user_data_out, pack_model());
    chk("rstack_stb", user_wr_stb, 4'h0);
    @(negedge clk);
    rst = 1'b0;
    acks = 0;
    repeat (4) begin
      @(negedge clk);
      if (sl_xferack) acks++;
    end
    chk("no_reack", acks, 0);
    opb_select = 1'b0;
    @(negedge clk);
    do_xfer(BASE + 32'd8, 1'b1, 4'b0000, 32'h0);

    // Randomized traffic
    for (int n = 0; n < 60; n++) begin
      sel = $urandom_range(0, 9);
      if (sel < 6)      a = BASE + 32'(4 * (sel % NREGS)) + 32'($urandom_range(0, 3));
      else if (sel < 8) a = BASE + 32'(4 * $urandom_range(NREGS, 63)) + 32'($urandom_range(0, 3));
      else if (sel == 8) a = BASE - 32'($urandom_range(1, 64));
      else              a = HIGH + 32'($urandom_range(1, 256));
      do_xfer(a, 1'($urandom_range(0, 1)), 4'($urandom), $urandom);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
